// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback unit: FSM states, RV32I load funct3 codes,
// default widths and the load legality check.
package wb_unit_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // A load may go to memory only with a defined funct3 and natural alignment.
    function automatic logic load_ok(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LB, LBU: load_ok = 1'b1;
            LH, LHU: load_ok = ~off[0];
            LW:      load_ok = (off == 2'b00);
            default: load_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Bus bundle between execute stage, data memory and register file write port.
// WB_BYPASS_EN adds the decode bypass signals byp_raddr/byp_hit/byp_data.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// the initiator holds valid and its payload stable until that edge.
interface wb_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rd_wen;
    logic                  in_is_load;
    logic [2:0]            in_funct3;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  wb_retire;
    logic                  wb_err;
`ifdef WB_BYPASS_EN
    logic [ADDR_WIDTH-1:0] byp_raddr;
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
`endif

    modport slave (
`ifdef WB_BYPASS_EN
        input  byp_raddr,
        output byp_hit, byp_data,
`endif
        input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_result,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output in_ready, mem_req_valid, mem_addr,
        output rf_wen, rf_waddr, rf_wdata, wb_retire, wb_err
    );

    modport master (
`ifdef WB_BYPASS_EN
        output byp_raddr,
        input  byp_hit, byp_data,
`endif
        output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_result,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  in_ready, mem_req_valid, mem_addr,
        input  rf_wen, rf_waddr, rf_wdata, wb_retire, wb_err
    );

endinterface

// File: rtl/wb_unit_load_extend.sv
// Combinational load data alignment and sign/zero extension for RV32I loads.
module load_extend
    import wb_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            off,
    output logic [DATA_WIDTH-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[16 +: 16] : rdata[0 +: 16];
        case (funct3)
            LB:      data = {{(DATA_WIDTH-8){b[7]}}, b};
            LBU:     data = {{(DATA_WIDTH-8){1'b0}}, b};
            LH:      data = {{(DATA_WIDTH-16){h[15]}}, h};
            LHU:     data = {{(DATA_WIDTH-16){1'b0}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: retires ALU results directly, runs loads through a single-beat
// memory read, and drives a registered register-file write pulse.
// Optional decode bypass port enabled with WB_BYPASS_EN.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_unit_if.slave   bus,
    output state_t     dbg_state
);
    state_t                state;
    logic                  rf_wen_r;
    logic [ADDR_WIDTH-1:0] rf_waddr_r;
    logic [DATA_WIDTH-1:0] rf_wdata_r;
    logic                  req_valid_r;
    logic [DATA_WIDTH-1:0] mem_addr_r;
    logic                  retire_r;
    logic                  err_r;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rd_wen_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] ext_data;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .rdata  (bus.mem_rdata),
        .funct3 (funct3_q),
        .off    (off_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rf_wen_r    <= 1'b0;
            rf_waddr_r  <= '0;
            rf_wdata_r  <= '0;
            req_valid_r <= 1'b0;
            mem_addr_r  <= '0;
            retire_r    <= 1'b0;
            err_r       <= 1'b0;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
        end else begin
            rf_wen_r <= 1'b0;
            retire_r <= 1'b0;
            err_r    <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (bus.in_valid) begin
                        if (!bus.in_is_load) begin
                            state      <= WRITE;
                            rf_wen_r   <= bus.in_rd_wen && (bus.in_rd != '0);
                            rf_waddr_r <= bus.in_rd;
                            rf_wdata_r <= bus.in_result;
                            retire_r   <= 1'b1;
                        end else if (load_ok(bus.in_funct3, bus.in_result[1:0])) begin
                            state       <= REQ;
                            req_valid_r <= 1'b1;
                            mem_addr_r  <= {bus.in_result[DATA_WIDTH-1:2], 2'b00};
                            rd_q        <= bus.in_rd;
                            rd_wen_q    <= bus.in_rd_wen;
                            funct3_q    <= bus.in_funct3;
                            off_q       <= bus.in_result[1:0];
                        end else begin
                            // Faulting load completes without touching memory or the register file.
                            state    <= WRITE;
                            err_r    <= 1'b1;
                            retire_r <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state      <= WRITE;
                        rf_wen_r   <= rd_wen_q && (rd_q != '0);
                        rf_waddr_r <= rd_q;
                        rf_wdata_r <= ext_data;
                        retire_r   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE) || (state == WRITE);
    assign bus.mem_req_valid = req_valid_r;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.rf_wen        = rf_wen_r;
    assign bus.rf_waddr      = rf_waddr_r;
    assign bus.rf_wdata      = rf_wdata_r;
    assign bus.wb_retire     = retire_r;
    assign bus.wb_err        = err_r;
    assign dbg_state         = state;

`ifdef WB_BYPASS_EN
    // Lets decode read the value being written this very cycle.
    assign bus.byp_hit  = rf_wen_r && (rf_waddr_r == bus.byp_raddr) && (bus.byp_raddr != '0);
    assign bus.byp_data = rf_wdata_r;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: driver tasks push expected writebacks into exp_q,
// a negedge monitor pops and compares them on every wb_retire pulse.
module tb_wb_unit;
    import wb_unit_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = 2 + AW + DW;   // {wen, err, waddr, wdata}

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    wb_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic wen, input logic err,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {wen, err, a, d};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rf_wen && !bus.wb_retire) begin
                checks++;
                errors++;
                $display("FAIL wen_without_retire actual=1 required=0");
            end
            if (bus.wb_retire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire waddr=%0d wdata=0x%0h required=none", bus.rf_waddr, bus.rf_wdata);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("sb_wen", DW'(bus.rf_wen), DW'(e[W-1]));
                    check("sb_err", DW'(bus.wb_err), DW'(e[W-2]));
                    if (e[W-1]) begin
                        check("sb_waddr", DW'(bus.rf_waddr), DW'(e[DW +: AW]));
                        check("sb_wdata", bus.rf_wdata, e[DW-1:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic rd_wen, input logic is_load,
                         input logic [2:0] f3, input logic [DW-1:0] result);
        bus.in_valid   = 1'b1;
        bus.in_rd      = rd;
        bus.in_rd_wen  = rd_wen;
        bus.in_is_load = is_load;
        bus.in_funct3  = f3;
        bus.in_result  = result;
        for (int i = 0; i < 20 && !bus.in_ready; i++) step();
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] result);
        exp_q.push_back(pack(rd != '0, 1'b0, rd, result));
        issue(rd, 1'b1, 1'b0, 3'b000, result);
    endtask

    task automatic load(input logic [AW-1:0] rd, input logic [2:0] f3, input logic [DW-1:0] addr,
                        input logic [DW-1:0] rdata, input int delay, input logic exp_err,
                        input logic [DW-1:0] exp_data);
        if (exp_err) begin
            exp_q.push_back(pack(1'b0, 1'b1, rd, '0));
            issue(rd, 1'b1, 1'b1, f3, addr);
            check("err_no_req", DW'(bus.mem_req_valid), 0);
            return;
        end
        exp_q.push_back(pack(rd != '0, 1'b0, rd, exp_data));
        issue(rd, 1'b1, 1'b1, f3, addr);
        check("req_valid", DW'(bus.mem_req_valid), 1);
        check("req_addr", bus.mem_addr, addr & ~32'd3);
        for (int i = 0; i < delay; i++) begin
            step();
            check("req_valid_held", DW'(bus.mem_req_valid), 1);
            check("req_addr_held", bus.mem_addr, addr & ~32'd3);
        end
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("req_dropped", DW'(bus.mem_req_valid), 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wen"}, DW'(bus.rf_wen), 0);
        check({tag, "_waddr"}, DW'(bus.rf_waddr), 0);
        check({tag, "_wdata"}, bus.rf_wdata, 0);
        check({tag, "_req_valid"}, DW'(bus.mem_req_valid), 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_retire"}, DW'(bus.wb_retire), 0);
        check({tag, "_err"}, DW'(bus.wb_err), 0);
        check({tag, "_state"}, DW'(dbg_state), DW'(IDLE));
        check({tag, "_in_ready"}, DW'(bus.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_rd         = '0;
        bus.in_rd_wen     = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_funct3     = '0;
        bus.in_result     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
`ifdef WB_BYPASS_EN
        bus.byp_raddr     = '0;
`endif
        rst_n = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single ALU op: write visible the cycle after acceptance
        alu(5'd5, 32'h1234_5678);
        check("alu_wen_n1", DW'(bus.rf_wen), 1);
        check("alu_waddr_n1", DW'(bus.rf_waddr), 5);
        check("alu_wdata_n1", bus.rf_wdata, 32'h1234_5678);
        check("alu_retire_n1", DW'(bus.wb_retire), 1);
`ifdef WB_BYPASS_EN
        bus.byp_raddr = 5'd5;
        #1;
        check("byp_hit", DW'(bus.byp_hit), 1);
        check("byp_data", bus.byp_data, 32'h1234_5678);
        bus.byp_raddr = 5'd0;
        #1;
        check("byp_hit_r0", DW'(bus.byp_hit), 0);
`endif
        step();

        // Back-to-back ALU ops, rd=0 must not write
        check("b2b_ready0", DW'(bus.in_ready), 1);
        alu(5'd1, 32'h0000_000A);
        check("b2b_ready1", DW'(bus.in_ready), 1);
        alu(5'd2, 32'h0000_000B);
        check("b2b_ready2", DW'(bus.in_ready), 1);
        alu(5'd0, 32'h0000_000C);
        check("b2b_r0_wen", DW'(bus.rf_wen), 0);
        check("b2b_r0_retire", DW'(bus.wb_retire), 1);
        step();

        // Loads: hand-computed extension results
        load(5'd3, LB,  32'h0000_0103, 32'h80FF_0000, 2, 1'b0, 32'hFFFF_FF80);
        load(5'd4, LHU, 32'h0000_0102, 32'hBEEF_1234, 0, 1'b0, 32'h0000_BEEF);
        load(5'd6, LW,  32'h0000_0101, 32'h0,         0, 1'b1, 32'h0);
        load(5'd8, LH,  32'h0000_0100, 32'h0000_8001, 1, 1'b0, 32'hFFFF_8001);
        load(5'd9, LBU, 32'h0000_0101, 32'h0000_F000, 0, 1'b0, 32'h0000_00F0);
        load(5'd10, LW, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
        alu(5'd11, 32'h5555_AAAA);
        load(5'd12, 3'b011, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h0);
        load(5'd13, LH, 32'h0000_0101, 32'h0, 0, 1'b1, 32'h0);
        load(5'd14, 3'b110, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h0);
        load(5'd0, LW, 32'h0000_0108, 32'h1111_2222, 0, 1'b0, 32'h1111_2222);
        load(5'd15, LB, 32'h0000_0101, 32'h0000_7F00, 0, 1'b0, 32'h0000_007F);
        step();

        // Reset while waiting for read data, then a stray rvalid
        issue(5'd7, 1'b1, 1'b1, LW, 32'h0000_0200);
        check("rst_req_valid", DW'(bus.mem_req_valid), 1);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("rst_in_wait", DW'(dbg_state), DW'(WAIT));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle_outputs("midrst");
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        step();
        bus.mem_rvalid = 1'b0;
        check("stray_rv_wen", DW'(bus.rf_wen), 0);
        check("stray_rv_retire", DW'(bus.wb_retire), 0);
        check("stray_rv_state", DW'(dbg_state), DW'(IDLE));
        repeat (3) step();

        check("sb_drained", DW'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
